inst_loader: RTL
================

# inst_loader

Program loader for the single-cycle RI CPU's instruction memory. It receives a length-prefixed, checksummed byte stream over a valid/ready interface and assembles the bytes into 32-bit instruction words. It writes each word into the 64-word instruction RAM read by the fetch stage, and holds the CPU in reset for the whole load. The CPU is released only after a load completes with a correct checksum.

## Interface
Parameters:
- ADDR_W, 6, instruction RAM word-address width (depth 2^ADDR_W = 64).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  instruction RAM write enable.
- im_addr  out  ADDR_W  instruction RAM word address.
- im_wdata  out  32  instruction word to write.
- cpu_rst  out  1  reset to the CPU and fetch stage; high holds the CPU.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- err  out  1  last load failed its checksum.
- word_cnt  out  ADDR_W+1  number of words written in the current or last load.

## Operation
- A byte transfers when in_valid and in_ready are both high at a posedge. in_data is don't-care otherwise.
- Stream format:
  - One length byte L gives the word count N. N = L for L = 1..64. L = 0 means N = 64. L > 64 means N = 64 (values saturate).
  - Then 4N data bytes, big-endian per word: the first byte goes to im_wdata[31:24], the fourth to [7:0].
  - Then one checksum byte equal to the XOR of all 4N data bytes. The length byte is excluded.
- States:
  - IDLE
    - in_ready=0, busy=0, cpu_rst=0.
    - start -> LEN.
  - LEN
    - in_ready=1, busy=1, cpu_rst=1.
    - Entry clears word_cnt, byte index, the running XOR and the done/err flags.
    - On a byte: latch N -> DATA.
  - DATA
    - in_ready=1.
    - Each byte shifts into the word register and updates the XOR.
    - After the 4th byte -> WRITE.
  - WRITE
    - Lasts one cycle.
    - in_ready=0, im_we=1, im_addr=word_cnt[ADDR_W-1:0], im_wdata=assembled word.
    - word_cnt increments at the end of the cycle.
    - If the new word_cnt equals N -> CSUM, else -> DATA.
  - CSUM
    - in_ready=1.
    - On a byte: if it equals the XOR -> DONE with done=1, else -> ERR with err=1.
  - DONE
    - cpu_rst=0, busy=0, done=1.
    - start -> LEN.
  - ERR
    - cpu_rst=1, busy=0, err=1.
    - start -> LEN.
- start asserted in LEN, DATA, WRITE or CSUM is ignored.
- im_we is high only in WRITE. Outside WRITE, im_addr and im_wdata hold their last values.

## Timing
- Reset values (async, immediate):
  - state=IDLE, cpu_rst=1, in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, word_cnt=0.
- cpu_rst is registered.
  - It drops to 0 at the first posedge after rst deasserts, because the block is then in IDLE.
  - It rises in the cycle after start is sampled in IDLE or DONE.
  - It falls in the cycle after a good checksum byte is accepted.
- in_ready is decoded from the registered state, so it has no combinational path from in_valid.
- im_we is high for exactly one cycle, the cycle after the handshake of a word's 4th byte.
- Peak throughput is 4 bytes per 5 cycles. A minimal load of N words takes 1 + 5N + 1 cycles from the first LEN cycle to DONE.
- Gaps in in_valid stall the block in its current state with no side effects.
- rst asserted at any time, including mid-WRITE, returns all outputs to their reset values at once. RAM words already written stay in the RAM and are not invalid.
- The RAM is written on the posedge at which im_we is high. The fetch stage does not read the RAM while cpu_rst=1.

## Test plan
- Good load:
  - Stimulus: start, then bytes 02, 20 01 00 05, 00 22 18 20, 3E.
  - Required: writes addr0=0x20010005 and addr1=0x00221820.
  - Required: done=1, err=0, word_cnt=2, cpu_rst falls the cycle after 3E is accepted.
- Bad checksum:
  - Stimulus: same stream ending in 3F.
  - Required: err=1, done=0, cpu_rst stays 1.
  - Required: a following start plus a good stream recovers to done=1.
- Full depth:
  - Stimulus: L=00 followed by 256 bytes holding the word pattern 0x00000000..0x0000003F, then the matching checksum.
  - Required: 64 writes, last write im_addr=63, word_cnt=64, done=1.
- Backpressure and gaps:
  - Stimulus: in_valid toggled randomly during the good-load stream; in_valid held high through WRITE.
  - Required: no byte accepted while in_ready=0.
  - Required: written words and checksum identical to the good-load case.
- Reset mid-load:
  - Stimulus: assert rst after the 6th data byte.
  - Required: immediately state=IDLE, cpu_rst=1, im_we=0, word_cnt=0; one posedge after rst deasserts, cpu_rst=0.
- start while busy:
  - Stimulus: pulse start in DATA.
  - Required: no effect on the load.
  - Required: start in DONE re-raises cpu_rst next cycle and clears done.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction RAM
// and holds the CPU in reset until a load completes with a matching checksum.
module inst_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic              r_cpu_rst;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_word_cnt;
    logic [1:0]        r_bidx;
    logic [7:0]        r_xor;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_im_addr;
    logic [31:0]       r_im_wdata;
    logic              r_done;
    logic              r_err;
    logic              w_hs;
    logic              w_len_sat;
    logic [ADDR_W:0]   w_len;
    logic [ADDR_W:0]   w_cnt_inc;
    logic [31:0]       w_word_next;

    assign in_ready    = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
    assign busy        = in_ready || (r_state == WRITE);
    assign im_we       = (r_state == WRITE);
    assign im_addr     = r_im_addr;
    assign im_wdata    = r_im_wdata;
    assign cpu_rst     = r_cpu_rst;
    assign done        = r_done;
    assign err         = r_err;
    assign word_cnt    = r_word_cnt;
    assign w_hs        = in_valid && in_ready;
    assign w_cnt_inc   = r_word_cnt + 1'b1;
    assign w_word_next = {r_word[23:0], in_data};
    // Zero and anything above the RAM depth both mean a full-depth load.
    assign w_len_sat   = (in_data == 8'd0) || (32'(in_data) > 32'(DEPTH));
    assign w_len       = w_len_sat ? DEPTH : (ADDR_W+1)'(in_data);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERR: w_next = start ? LEN : r_state;
            LEN:             w_next = w_hs ? DATA : LEN;
            DATA:            w_next = (w_hs && r_bidx == 2'd3) ? WRITE : DATA;
            WRITE:           w_next = (w_cnt_inc == r_n) ? CSUM : DATA;
            CSUM:            w_next = w_hs ? ((in_data == r_xor) ? DONE : ERR) : CSUM;
            default:         w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cpu_rst  <= 1'b1;
            r_n        <= '0;
            r_word_cnt <= '0;
            r_bidx     <= '0;
            r_xor      <= '0;
            r_word     <= '0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cpu_rst <= !(w_next == IDLE || w_next == DONE);
            if (r_state != LEN && w_next == LEN) begin
                r_word_cnt <= '0;
                r_bidx     <= '0;
                r_xor      <= '0;
                r_done     <= 1'b0;
                r_err      <= 1'b0;
            end
            if (r_state == LEN && w_hs)
                r_n <= w_len;
            if (r_state == DATA && w_hs) begin
                r_word <= w_word_next;
                r_xor  <= r_xor ^ in_data;
                r_bidx <= r_bidx + 1'b1;
                // The RAM port registers only change when a whole word is ready.
                if (r_bidx == 2'd3) begin
                    r_im_wdata <= w_word_next;
                    r_im_addr  <= r_word_cnt[ADDR_W-1:0];
                end
            end
            if (r_state == WRITE)
                r_word_cnt <= w_cnt_inc;
            if (r_state == CSUM && w_hs) begin
                r_done <= (in_data == r_xor);
                r_err  <= (in_data != r_xor);
            end
        end
    end
endmodule
